// File: rtl/alu_ctrl_ext_pkg.sv
// Shared constants for the ALU/control/extend block.
//   - MIPS opcode and funct field values for the supported instruction set
//   - ALU operation codes driven on ctrl_alu
//   - Mux-select encodings for reg_dst, alu_src_a, alu_src_b, mem2reg
//   - ctrl_t: the bundle of decoded controls produced by instruction decode
package alu_ctrl_ext_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10
    } alu_op_e;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Mux-select encodings
    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] SRC_A_RS    = 2'd0;
    localparam logic [1:0] SRC_A_C16   = 2'd1;
    localparam logic [1:0] SRC_A_SHAMT = 2'd2;

    localparam logic [1:0] SRC_B_RT    = 2'd0;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;

    localparam logic [1:0] M2R_ALU     = 2'd0;
    localparam logic [1:0] M2R_MEM     = 2'd1;
    localparam logic [1:0] M2R_PC4     = 2'd2;

    typedef struct packed {
        alu_op_e    alu_op;
        logic [1:0] reg_dst;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] mem2reg;
        logic       ext_sel;
        logic       reg_wr;
        logic       mem_wr;
        logic       ovf_chk;   // instruction traps-on-overflow class (add/sub/addi)
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_ext_alu_core.sv
// Combinational 32-bit ALU.
//   a      : operand A (shift amount taken from a[4:0])
//   b      : operand B (value being shifted for shift ops)
//   op     : ALU operation code; codes 11-31 yield 0
//   result : operation result, modulo 2^32
//   ovf    : signed overflow of ADD/SUB, 0 for every other op
module alu_core
    import alu_ctrl_ext_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic        [DATA_W-1:0] sum;
    logic        [DATA_W-1:0] diff;

    assign a_s  = a;
    assign b_s  = b;
    assign sum  = a + b;
    assign diff = a - b;

    function automatic logic add_ovf(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                     input logic [DATA_W-1:0] r);
        return (x[DATA_W-1] == y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                     input logic [DATA_W-1:0] r);
        return (x[DATA_W-1] != y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD:  begin result = sum;  ovf = add_ovf(a, b, sum);  end
            ALU_SUB:  begin result = diff; ovf = sub_ovf(a, b, diff); end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << a[4:0];
            ALU_SRL:  result = b >> a[4:0];
            ALU_SRA:  result = b_s >>> a[4:0];
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_ext.sv
// MIPS decode + immediate extend + execute, with one registered output stage.
//   clk, rst (async, active-low)
//   in_valid, instr, rs_data, rt_data  : instruction and operands for this cycle
//   out_valid                          : registered outputs below are valid
//   alu_result, zero, ovf              : registered execute results
//   ctrl_alu, reg_dst, alu_src_a, alu_src_b, mem2reg, ext_sel, reg_wr, mem_wr
//                                      : registered decoded controls
//   ext_imm                            : registered extended immediate
// Build option: define ALU_OVF_EN to flag signed overflow on add/sub/addi and
// suppress the register write of the overflowing instruction. Without it, ovf
// is tied 0 and add/sub behave exactly like addu/subu.
module alu_ctrl_ext
    import alu_ctrl_ext_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              ovf,
    output logic [4:0]        ctrl_alu,
    output logic [1:0]        reg_dst,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        mem2reg,
    output logic              ext_sel,
    output logic              reg_wr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] ext_imm
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    ctrl_t       ctrl;

    logic [DATA_W-1:0] ext_imm_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [DATA_W-1:0] alu_res_p0;
    logic              core_ovf;
    logic              ovf_p0;
    logic              reg_wr_p0;
    logic              zero_p0;

    // Register indices (rs/rt fields) are resolved before this block.
    logic unused_fields;
    assign unused_fields = ^instr[25:16];

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    // ---- Stage p0: decode, extend, operand select, execute ----
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst = REG_DST_RD;
                ctrl.reg_wr  = 1'b1;
                case (funct)
                    FN_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.ovf_chk = 1'b1; end
                    FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.ovf_chk = 1'b1; end
                    FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLTU: ctrl.alu_op = ALU_SLTU;
                    FN_SLL:  begin ctrl.alu_op = ALU_SLL; ctrl.src_a = SRC_A_SHAMT; end
                    FN_SRL:  begin ctrl.alu_op = ALU_SRL; ctrl.src_a = SRC_A_SHAMT; end
                    FN_SRA:  begin ctrl.alu_op = ALU_SRA; ctrl.src_a = SRC_A_SHAMT; end
                    FN_SLLV: ctrl.alu_op = ALU_SLL;
                    FN_SRLV: ctrl.alu_op = ALU_SRL;
                    FN_SRAV: ctrl.alu_op = ALU_SRA;
                    FN_JALR: ctrl.mem2reg = M2R_PC4;
                    default: ctrl = '0;   // jr and unknown functs: no writes
                endcase
            end
            OP_ADDI: begin
                ctrl.src_b = SRC_B_IMM; ctrl.ext_sel = 1'b1; ctrl.reg_wr = 1'b1;
                ctrl.ovf_chk = 1'b1;
            end
            OP_ADDIU: begin
                ctrl.src_b = SRC_B_IMM; ctrl.ext_sel = 1'b1; ctrl.reg_wr = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_op = ALU_SLT; ctrl.src_b = SRC_B_IMM; ctrl.ext_sel = 1'b1;
                ctrl.reg_wr = 1'b1;
            end
            OP_SLTIU: begin
                ctrl.alu_op = ALU_SLTU; ctrl.src_b = SRC_B_IMM; ctrl.ext_sel = 1'b1;
                ctrl.reg_wr = 1'b1;
            end
            OP_ANDI: begin ctrl.alu_op = ALU_AND; ctrl.src_b = SRC_B_IMM; ctrl.reg_wr = 1'b1; end
            OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.src_b = SRC_B_IMM; ctrl.reg_wr = 1'b1; end
            OP_XORI: begin ctrl.alu_op = ALU_XOR; ctrl.src_b = SRC_B_IMM; ctrl.reg_wr = 1'b1; end
            OP_LUI: begin
                // lui = zero-extended immediate shifted left by the constant 16
                ctrl.alu_op = ALU_SLL; ctrl.src_a = SRC_A_C16; ctrl.src_b = SRC_B_IMM;
                ctrl.reg_wr = 1'b1;
            end
            OP_LW: begin
                ctrl.src_b = SRC_B_IMM; ctrl.ext_sel = 1'b1; ctrl.mem2reg = M2R_MEM;
                ctrl.reg_wr = 1'b1;
            end
            OP_SW: begin
                ctrl.src_b = SRC_B_IMM; ctrl.ext_sel = 1'b1; ctrl.mem_wr = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op = ALU_SUB; ctrl.ext_sel = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_dst = REG_DST_R31; ctrl.mem2reg = M2R_PC4; ctrl.reg_wr = 1'b1;
            end
            default: ctrl = '0;   // j and unknown opcodes
        endcase
    end

    assign ext_imm_p0 = ctrl.ext_sel ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};

    always_comb begin
        case (ctrl.src_a)
            SRC_A_C16:   a_p0 = 32'd16;
            SRC_A_SHAMT: a_p0 = {27'd0, instr[10:6]};
            default:     a_p0 = rs_data;
        endcase
    end

    assign b_p0 = (ctrl.src_b == SRC_B_IMM) ? ext_imm_p0 : rt_data;

    alu_core u_alu_core (
        .a      (a_p0),
        .b      (b_p0),
        .op     (ctrl.alu_op),
        .result (alu_res_p0),
        .ovf    (core_ovf)
    );

    assign zero_p0 = (alu_res_p0 == '0);

`ifdef ALU_OVF_EN
    assign ovf_p0    = ctrl.ovf_chk & core_ovf;
    assign reg_wr_p0 = ctrl.reg_wr & ~ovf_p0;
`else
    logic unused_ovf;
    assign unused_ovf = core_ovf ^ ctrl.ovf_chk;
    assign ovf_p0     = 1'b0;
    assign reg_wr_p0  = ctrl.reg_wr;
`endif

    // ---- Stage p1: registered outputs ----
    logic              vld_p1;
    logic [DATA_W-1:0] alu_result_p1;
    logic              zero_p1;
    logic              ovf_p1;
    ctrl_t             ctrl_p1;
    logic [DATA_W-1:0] ext_imm_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1        <= 1'b0;
            alu_result_p1 <= '0;
            zero_p1       <= 1'b0;
            ovf_p1        <= 1'b0;
            ctrl_p1       <= '0;
            ext_imm_p1    <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                alu_result_p1  <= alu_res_p0;
                zero_p1        <= zero_p0;
                ovf_p1         <= ovf_p0;
                ctrl_p1        <= ctrl;
                ctrl_p1.reg_wr <= reg_wr_p0;
                ext_imm_p1     <= ext_imm_p0;
            end else begin
                // Bubble: strobes drop, everything else holds
                ctrl_p1.reg_wr <= 1'b0;
                ctrl_p1.mem_wr <= 1'b0;
            end
        end
    end

    assign out_valid  = vld_p1;
    assign alu_result = alu_result_p1;
    assign zero       = zero_p1;
    assign ovf        = ovf_p1;
    assign ctrl_alu   = ctrl_p1.alu_op;
    assign reg_dst    = ctrl_p1.reg_dst;
    assign alu_src_a  = ctrl_p1.src_a;
    assign alu_src_b  = ctrl_p1.src_b;
    assign mem2reg    = ctrl_p1.mem2reg;
    assign ext_sel    = ctrl_p1.ext_sel;
    assign reg_wr     = ctrl_p1.reg_wr;
    assign mem_wr     = ctrl_p1.mem_wr;
    assign ext_imm    = ext_imm_p1;

endmodule

// File: tb/tb_alu_ctrl_ext.sv
// Scoreboard bench for alu_ctrl_ext: the driver pushes expected responses from
// an instruction-level reference model; the monitor pops and compares on every
// falling edge. Honours ALU_OVF_EN the same way the design does.
module tb_alu_ctrl_ext;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ovf;
        logic [4:0]  op;
        logic [1:0]  rd;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  m2r;
        logic        es;
        logic        rw;
        logic        mw;
        logic [31:0] imm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        zero;
    logic        ovf;
    logic [4:0]  ctrl_alu;
    logic [1:0]  reg_dst;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  mem2reg;
    logic        ext_sel;
    logic        reg_wr;
    logic        mem_wr;
    logic [31:0] ext_imm;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t last;

    alu_ctrl_ext dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .out_valid  (out_valid),
        .alu_result (alu_result),
        .zero       (zero),
        .ovf        (ovf),
        .ctrl_alu   (ctrl_alu),
        .reg_dst    (reg_dst),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .mem2reg    (mem2reg),
        .ext_sel    (ext_sel),
        .reg_wr     (reg_wr),
        .mem_wr     (mem_wr),
        .ext_imm    (ext_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{res: 32'd0, z: 1'b0, ovf: 1'b0, op: 5'd0, rd: 2'd0, sa: 2'd0, sb: 2'd0,
              m2r: 2'd0, es: 1'b0, rw: 1'b0, mw: 1'b0, imm: 32'd0};
        return e;
    endfunction

    function automatic logic s_ovf(input logic [31:0] x, input logic [31:0] y, input bit sub);
        longint s;
        s = sub ? (longint'($signed(x)) - longint'($signed(y)))
                : (longint'($signed(x)) + longint'($signed(y)));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Instruction-level reference: result computed straight from the mnemonic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t               e;
        logic [5:0]         opc;
        logic [5:0]         fn;
        logic [4:0]         sh;
        logic [31:0]        sx;
        logic [31:0]        zx;
        logic signed [31:0] rt_s;
        bit                 chk_ovf;
        bit                 ov;
        e       = zero_exp();
        opc     = ins[31:26];
        fn      = ins[5:0];
        sh      = ins[10:6];
        sx      = {{16{ins[15]}}, ins[15:0]};
        zx      = {16'h0, ins[15:0]};
        rt_s    = rt;
        chk_ovf = 0;
        ov      = 0;
        e.res   = rs + rt;   // unknown / jump forms fall through as ADD rs+rt
        if (opc == 6'h00) begin
            e.rd = 2'd1; e.rw = 1'b1;
            case (fn)
                6'h20: begin e.res = rs + rt; chk_ovf = 1; ov = s_ovf(rs, rt, 0); end
                6'h21: e.res = rs + rt;
                6'h22: begin e.res = rs - rt; e.op = 5'd1; chk_ovf = 1; ov = s_ovf(rs, rt, 1); end
                6'h23: begin e.res = rs - rt; e.op = 5'd1; end
                6'h24: begin e.res = rs & rt; e.op = 5'd2; end
                6'h25: begin e.res = rs | rt; e.op = 5'd3; end
                6'h26: begin e.res = rs ^ rt; e.op = 5'd4; end
                6'h27: begin e.res = ~(rs | rt); e.op = 5'd5; end
                6'h2A: begin e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; e.op = 5'd6; end
                6'h2B: begin e.res = (rs < rt) ? 32'd1 : 32'd0; e.op = 5'd7; end
                6'h00: begin e.res = rt << sh; e.op = 5'd8; e.sa = 2'd2; end
                6'h02: begin e.res = rt >> sh; e.op = 5'd9; e.sa = 2'd2; end
                6'h03: begin e.res = rt_s >>> sh; e.op = 5'd10; e.sa = 2'd2; end
                6'h04: begin e.res = rt << rs[4:0]; e.op = 5'd8; end
                6'h06: begin e.res = rt >> rs[4:0]; e.op = 5'd9; end
                6'h07: begin e.res = rt_s >>> rs[4:0]; e.op = 5'd10; end
                6'h09: e.m2r = 2'd2;
                default: begin e.rd = 2'd0; e.rw = 1'b0; end
            endcase
        end else begin
            case (opc)
                6'h08: begin e.res = rs + sx; e.es = 1; e.sb = 1; e.rw = 1; chk_ovf = 1; ov = s_ovf(rs, sx, 0); end
                6'h09: begin e.res = rs + sx; e.es = 1; e.sb = 1; e.rw = 1; end
                6'h0A: begin e.res = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; e.op = 5'd6; e.es = 1; e.sb = 1; e.rw = 1; end
                6'h0B: begin e.res = (rs < sx) ? 32'd1 : 32'd0; e.op = 5'd7; e.es = 1; e.sb = 1; e.rw = 1; end
                6'h0C: begin e.res = rs & zx; e.op = 5'd2; e.sb = 1; e.rw = 1; end
                6'h0D: begin e.res = rs | zx; e.op = 5'd3; e.sb = 1; e.rw = 1; end
                6'h0E: begin e.res = rs ^ zx; e.op = 5'd4; e.sb = 1; e.rw = 1; end
                6'h0F: begin e.res = {ins[15:0], 16'h0}; e.op = 5'd8; e.sa = 1; e.sb = 1; e.rw = 1; end
                6'h23: begin e.res = rs + sx; e.es = 1; e.sb = 1; e.m2r = 1; e.rw = 1; end
                6'h2B: begin e.res = rs + sx; e.es = 1; e.sb = 1; e.mw = 1; end
                6'h04, 6'h05: begin e.res = rs - rt; e.op = 5'd1; e.es = 1; end
                6'h03: begin e.rd = 2; e.m2r = 2; e.rw = 1; end
                default: ;
            endcase
        end
`ifdef ALU_OVF_EN
        if (chk_ovf && ov) begin
            e.ovf = 1'b1;
            e.rw  = 1'b0;
        end
`else
        if (chk_ovf && ov) e.ovf = 1'b0;
`endif
        e.imm = e.es ? sx : zx;
        e.z   = (e.res == 32'd0);
        return e;
    endfunction

    task automatic issue_exp(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                             input exp_t e, input bit release_rst);
        @(negedge clk);
        #1;
        if (release_rst) rst = 1'b1;
        in_valid = 1'b1;
        instr    = ins;
        rs_data  = rs;
        rt_data  = rt;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        issue_exp(ins, rs, rt, model(ins, rs, rt), 1'b0);
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        instr    = $urandom;
        rs_data  = $urandom;
        rt_data  = $urandom;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t e;
        last = zero_exp();
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_alu_result", alu_result, 32'd0);
                chk("rst_zero", 32'(zero), 32'd0);
                chk("rst_ovf", 32'(ovf), 32'd0);
                chk("rst_ctrl", {14'd0, ctrl_alu, reg_dst, alu_src_a, alu_src_b, mem2reg,
                                 ext_sel, reg_wr, mem_wr}, 32'd0);
                chk("rst_ext_imm", ext_imm, 32'd0);
                last = zero_exp();
            end else begin
                chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (out_valid) begin
                        chk("alu_result", alu_result, e.res);
                        chk("zero", 32'(zero), 32'(e.z));
                        chk("ovf", 32'(ovf), 32'(e.ovf));
                        chk("ctrl_alu", 32'(ctrl_alu), 32'(e.op));
                        chk("reg_dst", 32'(reg_dst), 32'(e.rd));
                        chk("alu_src_a", 32'(alu_src_a), 32'(e.sa));
                        chk("alu_src_b", 32'(alu_src_b), 32'(e.sb));
                        chk("mem2reg", 32'(mem2reg), 32'(e.m2r));
                        chk("ext_sel", 32'(ext_sel), 32'(e.es));
                        chk("reg_wr", 32'(reg_wr), 32'(e.rw));
                        chk("mem_wr", 32'(mem_wr), 32'(e.mw));
                        chk("ext_imm", ext_imm, e.imm);
                        last = e;
                    end
                end else if (!out_valid) begin
                    chk("idle_reg_wr", 32'(reg_wr), 32'd0);
                    chk("idle_mem_wr", 32'(mem_wr), 32'd0);
                    chk("hold_alu_result", alu_result, last.res);
                    chk("hold_flags", {30'd0, zero, ovf}, {30'd0, last.z, last.ovf});
                    chk("hold_ctrl", {21'd0, ctrl_alu, reg_dst, alu_src_a, alu_src_b, mem2reg, ext_sel},
                        {21'd0, last.op, last.rd, last.sa, last.sb, last.m2r, last.es});
                    chk("hold_ext_imm", ext_imm, last.imm);
                end
            end
        end
    end

    // Driver
    logic [5:0] fn_tab [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09};
    logic [5:0] op_tab [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    initial begin
        exp_t        e;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        int          waited;

        rst      = 1'b0;
        in_valid = 1'b0;
        instr    = 32'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        repeat (3) @(negedge clk);

        // addu: first valid output one edge after reset release
        e = model(32'h0022_1821, 32'd5, 32'd7);
        e.res = 32'd12; e.rd = 2'd1; e.rw = 1'b1;
        issue_exp(32'h0022_1821, 32'd5, 32'd7, e, 1'b1);

        // lui
        e = model(32'h3C01_1234, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        e.res = 32'h1234_0000; e.sa = 2'd1; e.es = 1'b0;
        issue_exp(32'h3C01_1234, 32'hDEAD_BEEF, 32'h0BAD_F00D, e, 1'b0);

        // beq with equal operands
        e = model(32'h1022_0003, 32'd9, 32'd9);
        e.res = 32'd0; e.z = 1'b1; e.rw = 1'b0; e.mw = 1'b0;
        issue_exp(32'h1022_0003, 32'd9, 32'd9, e, 1'b0);
        idle();

        // sra by 4 of the most negative value
        e = model(32'h0002_1903, 32'h1234_5678, 32'h8000_0000);
        e.res = 32'hF800_0000;
        issue_exp(32'h0002_1903, 32'h1234_5678, 32'h8000_0000, e, 1'b0);

        // slti: -2 < -1
        e = model(32'h2822_FFFF, 32'hFFFF_FFFE, 32'd0);
        e.res = 32'd1; e.imm = 32'hFFFF_FFFF;
        issue_exp(32'h2822_FFFF, 32'hFFFF_FFFE, 32'd0, e, 1'b0);

        // add overflowing the signed range
        e = model(32'h0022_1820, 32'h7FFF_FFFF, 32'd1);
        e.res = 32'h8000_0000;
`ifdef ALU_OVF_EN
        e.ovf = 1'b1; e.rw = 1'b0;
`else
        e.ovf = 1'b0; e.rw = 1'b1;
`endif
        issue_exp(32'h0022_1820, 32'h7FFF_FFFF, 32'd1, e, 1'b0);
        idle();
        idle();

        // Reset asserted between edges while outputs are live
        issue(32'h0022_1821, 32'd5, 32'd7);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("async_rst_alu_result", alu_result, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        e = model(32'h0022_1823, 32'd3, 32'd10);
        issue_exp(32'h0022_1823, 32'd3, 32'd10, e, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                ins = $urandom;
                k   = $urandom_range(0, 99);
                if (k < 45) begin
                    ins[31:26] = 6'h00;
                    ins[5:0]   = fn_tab[$urandom_range(0, 17)];
                end else if (k < 90) begin
                    ins[31:26] = op_tab[$urandom_range(0, 13)];
                end
                a = pick_operand();
                b = ($urandom_range(0, 9) == 0) ? a : pick_operand();
                issue(ins, a, b);
            end
        end
        idle();

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #1;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
